// File: rtl/rf_pkg.sv
// rf_pkg: shared definitions for the register-file write arbiter.
//   DEF_DATA_W / DEF_ADDR_W : default data and address widths
//   rf_state_e              : arbiter state (RF_CLEAR, RF_RUN)
//   RF_REQ_ALU / RF_REQ_LD  : requester indices used for last_grant
package rf_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;

    localparam logic RF_REQ_ALU = 1'b0;
    localparam logic RF_REQ_LD  = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin grant.
//   valid0, valid1 : request inputs
//   last_grant     : index of the most recently served requester
//   grant          : one-hot grant (bit N = requester N), zero when idle
// The round-robin pointer itself lives in the parent.
module rr_arb2
    import rf_pkg::*;
(
    input  logic       valid0,
    input  logic       valid1,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (valid0 && valid1) begin
            // Contention: serve whoever was not served last.
            grant = (last_grant == RF_REQ_LD) ? 2'b01 : 2'b10;
        end else if (valid0) begin
            grant = 2'b01;
        end else if (valid1) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: arbitrates the single REG_FILE write port between the
// ALU writeback path (req0) and the load/multi-cycle unit (req1).
//   clk, reset            : clock, synchronous active-high reset
//   reqN_valid/addr/data  : writeback request N (held until accepted)
//   reqN_ready            : request N accepted this cycle
//   write_en/w_addr/w_data: registered REG_FILE write port
//   busy                  : post-reset clear in progress
//   last_grant            : most recently accepted requester
// Build option: define RF_CLEAR_EN to zero registers 1..2^ADDR_W-1 after
// every reset before any request is accepted.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_W = rf_pkg::DEF_DATA_W,
    parameter int ADDR_W = rf_pkg::DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              write_en,
    output logic [ADDR_W-1:0] w_addr,
    output logic [DATA_W-1:0] w_data,
    output logic              busy,
    output logic              last_grant
);

    rf_state_e  state;
    logic [1:0] grant;
    logic       run;
    logic       xfer0;
    logic       xfer1;

`ifdef RF_CLEAR_EN
    logic [ADDR_W-1:0] clr_cnt;
    logic              busy_q;
    assign busy = busy_q;
`else
    assign busy = 1'b0;
`endif

    rr_arb2 u_arb (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Ready is masked by reset so nothing is accepted while reset is held.
    assign run        = (state == RF_RUN) && !reset;
    assign req0_ready = run && grant[0];
    assign req1_ready = run && grant[1];
    assign xfer0      = req0_valid && req0_ready;
    assign xfer1      = req1_valid && req1_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
`ifdef RF_CLEAR_EN
            state   <= RF_CLEAR;
            busy_q  <= 1'b1;
            clr_cnt <= ADDR_W'(1);
`else
            state   <= RF_RUN;
`endif
            last_grant <= RF_REQ_LD;
            write_en   <= 1'b0;
            w_addr     <= '0;
            w_data     <= '0;
        end else begin
            case (state)
`ifdef RF_CLEAR_EN
                RF_CLEAR: begin
                    write_en <= 1'b1;
                    w_addr   <= clr_cnt;
                    w_data   <= '0;
                    clr_cnt  <= clr_cnt + ADDR_W'(1);
                    // Issuing the top address ends the sweep; busy drops
                    // together with the state change.
                    if (clr_cnt == '1) begin
                        state  <= RF_RUN;
                        busy_q <= 1'b0;
                    end
                end
`endif
                RF_RUN: begin
                    if (xfer0) begin
                        last_grant <= RF_REQ_ALU;
                        w_addr     <= req0_addr;
                        w_data     <= req0_data;
                        // Register 0 is hardwired: handshake completes, no write.
                        write_en   <= (req0_addr != '0);
                    end else if (xfer1) begin
                        last_grant <= RF_REQ_LD;
                        w_addr     <= req1_addr;
                        w_data     <= req1_data;
                        write_en   <= (req1_addr != '0);
                    end else begin
                        write_en   <= 1'b0;
                    end
                end
                default: begin
                    state    <= RF_RUN;
                    write_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: randomized self-checking bench for rf_write_arbiter.
// Holds a simple register-file array driven by the DUT write port (the file
// ignores writes while reset is held) and a behavioural model of the grant
// rules, output registers and file contents.
module tb_rf_write_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic [AW-1:0] req0_addr = '0, req1_addr = '0;
    logic [DW-1:0] req0_data = '0, req1_data = '0;
    logic          req0_ready, req1_ready;
    logic          write_en;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic          busy;
    logic          last_grant;

    rf_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .write_en(write_en), .w_addr(w_addr), .w_data(w_data), .busy(busy), .last_grant(last_grant)
    );

    always #5 clk = ~clk;

    // Register file fed by the DUT.
    logic [DW-1:0] rf [NR];
    always @(posedge clk) if (write_en && !reset) rf[w_addr] <= w_data;

    // Reference model state.
    logic [DW-1:0] mem [NR];
    logic          m_we, m_lg;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic          e_r0, e_r1, obs_r0, obs_r1;

    int checks = 0;
    int errors = 0;

    // One clock: drive inputs after negedge, sample readies before the edge,
    // advance the model across the edge, leave outputs settled at edge+1.
    task automatic step(input logic rst, input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        @(negedge clk);
        reset = rst;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        #1;
        obs_r0 = req0_ready;
        obs_r1 = req1_ready;
        if (rst)           begin e_r0 = 1'b0;      e_r1 = 1'b0;      end
        else if (v0 && v1) begin e_r0 = (m_lg == 1'b1); e_r1 = (m_lg == 1'b0); end
        else               begin e_r0 = v0;        e_r1 = v1;        end
        @(posedge clk);
        #1;
        // Output presented in the previous cycle lands in the file now.
        if (!rst && m_we) mem[m_addr] = m_data;
        if (rst) begin
            m_we = 1'b0; m_addr = '0; m_data = '0; m_lg = 1'b1;
        end else if (e_r0) begin
            m_lg = 1'b0; m_addr = a0; m_data = d0; m_we = (a0 != 0);
        end else if (e_r1) begin
            m_lg = 1'b1; m_addr = a1; m_data = d1; m_we = (a1 != 0);
        end else begin
            m_we = 1'b0;
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

`ifdef RF_CLEAR_EN
    // Walks the post-reset clear sweep; called right after a reset step.
    task automatic run_clear();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL clear_busy_start got %0b want 1", busy); end
        for (int i = 1; i < NR; i++) begin
            step(1'b0, 1'b1, AW'(3), 32'hdead, 1'b1, AW'(4), 32'hbeef);
            checks++;
            if (obs_r0 !== 1'b0 || obs_r1 !== 1'b0) begin
                errors++; $display("FAIL clear_ready i=%0d got %0b%0b want 00", i, obs_r0, obs_r1);
            end
            checks++;
            if ({write_en, w_addr, w_data, busy} !== {1'b1, AW'(i), {DW{1'b0}}, (i != NR - 1)}) begin
                errors++;
                $display("FAIL clear_write i=%0d got we=%0b a=%0d d=%0h busy=%0b", i, write_en, w_addr, w_data, busy);
            end
            // The bench model did not grant during the sweep; restore it.
            if (i > 1) mem[i-1] = '0;
            m_we = 1'b1; m_addr = AW'(i); m_data = '0; m_lg = 1'b1;
        end
    endtask
`endif

    task automatic test_reset();
        step(1'b1, 1'b1, AW'(7), 32'h11, 1'b1, AW'(8), 32'h22);
        checks++;
        if (obs_r0 !== 1'b0 || obs_r1 !== 1'b0) begin
            errors++; $display("FAIL reset_ready got %0b%0b want 00", obs_r0, obs_r1);
        end
        checks++;
        if ({write_en, w_addr, w_data, last_grant} !== {1'b0, {AW{1'b0}}, {DW{1'b0}}, 1'b1}) begin
            errors++;
            $display("FAIL reset_outputs got we=%0b a=%0d d=%0h lg=%0b want 0 0 0 1", write_en, w_addr, w_data, last_grant);
        end
`ifdef RF_CLEAR_EN
        run_clear();
        idle();
        for (int r = 0; r < NR; r++) begin
            checks++;
            if (rf[r] !== '0) begin errors++; $display("FAIL clear_rf r=%0d got %0h want 0", r, rf[r]); end
        end
`else
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
`endif
    endtask

    task automatic test_single();
        step(1'b0, 1'b1, AW'(1), 32'd30, 1'b0, '0, '0);
        checks++;
        if (obs_r0 !== 1'b1 || {write_en, w_addr, w_data} !== {1'b1, AW'(1), 32'd30}) begin
            errors++; $display("FAIL single_first got rdy=%0b we=%0b a=%0d d=%0d want 1 1 1 30", obs_r0, write_en, w_addr, w_data);
        end
        step(1'b0, 1'b1, AW'(1), 32'd40, 1'b0, '0, '0);
        checks++;
        if (obs_r0 !== 1'b1 || {write_en, w_addr, w_data} !== {1'b1, AW'(1), 32'd40}) begin
            errors++; $display("FAIL single_second got rdy=%0b we=%0b a=%0d d=%0d want 1 1 1 40", obs_r0, write_en, w_addr, w_data);
        end
        idle();
        checks++;
        if (write_en !== 1'b0 || rf[1] !== 32'd40 || last_grant !== 1'b0) begin
            errors++; $display("FAIL single_done got we=%0b rf1=%0d lg=%0b want 0 40 0", write_en, rf[1], last_grant);
        end
    endtask

    task automatic test_contention();
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
`ifdef RF_CLEAR_EN
        run_clear();
`endif
        a0 = AW'(10); d0 = 32'h100; a1 = AW'(20); d1 = 32'h200;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, a0, d0, 1'b1, a1, d1);
            checks++;
            if (obs_r0 !== (i % 2 == 0) || obs_r1 !== (i % 2 == 1)) begin
                errors++; $display("FAIL contention_ready i=%0d got %0b%0b want %0b%0b", i, obs_r0, obs_r1, i % 2 == 0, i % 2 == 1);
            end
            checks++;
            if ({write_en, w_addr, w_data, last_grant} !== {m_we, m_addr, m_data, m_lg}) begin
                errors++; $display("FAIL contention_out i=%0d got a=%0d d=%0h want a=%0d d=%0h", i, w_addr, w_data, m_addr, m_data);
            end
            if (i % 2 == 0) begin a0 = a0 + 1'b1; d0 = d0 + 1; end
            else            begin a1 = a1 + 1'b1; d1 = d1 + 1; end
        end
        idle();
        checks++;
        if (rf[10] !== 32'h100 || rf[11] !== 32'h101 || rf[20] !== 32'h200 || rf[21] !== 32'h201) begin
            errors++; $display("FAIL contention_rf got %0h %0h %0h %0h want 100 101 200 201", rf[10], rf[11], rf[20], rf[21]);
        end
    endtask

    task automatic test_reg0();
        step(1'b0, 1'b0, '0, '0, 1'b1, AW'(0), 32'd20);
        checks++;
        if (obs_r1 !== 1'b1 || write_en !== 1'b0 || w_addr !== AW'(0) || w_data !== 32'd20) begin
            errors++; $display("FAIL reg0 got rdy=%0b we=%0b a=%0d d=%0d want 1 0 0 20", obs_r1, write_en, w_addr, w_data);
        end
        idle();
        checks++;
        if (rf[0] !== '0) begin errors++; $display("FAIL reg0_rf got %0h want 0", rf[0]); end
    endtask

    task automatic test_held();
        // last_grant is 1 here, so req0 wins the first contention.
        step(1'b0, 1'b1, AW'(12), 32'h55, 1'b1, AW'(13), 32'h77);
        checks++;
        if (obs_r0 !== 1'b1 || obs_r1 !== 1'b0) begin
            errors++; $display("FAIL held_first got %0b%0b want 10", obs_r0, obs_r1);
        end
        step(1'b0, 1'b0, '0, '0, 1'b1, AW'(13), 32'h77);
        checks++;
        if (obs_r1 !== 1'b1 || {write_en, w_addr, w_data} !== {1'b1, AW'(13), 32'h77}) begin
            errors++; $display("FAIL held_second got rdy=%0b we=%0b a=%0d d=%0h want 1 1 13 77", obs_r1, write_en, w_addr, w_data);
        end
        idle();
    endtask

    task automatic test_random();
        logic          v0 = 1'b0, v1 = 1'b0;
        logic [AW-1:0] a0 = '0, a1 = '0;
        logic [DW-1:0] d0 = '0, d1 = '0;
        for (int i = 0; i < 300; i++) begin
            if (!v0) begin v0 = ($urandom_range(0, 2) != 0); a0 = AW'($urandom_range(0, NR - 1)); d0 = $urandom; end
            if (!v1) begin v1 = ($urandom_range(0, 2) != 0); a1 = AW'($urandom_range(0, NR - 1)); d1 = $urandom; end
            step(1'b0, v0, a0, d0, v1, a1, d1);
            checks++;
            if (obs_r0 !== e_r0 || obs_r1 !== e_r1) begin
                errors++; $display("FAIL random_ready i=%0d got %0b%0b want %0b%0b", i, obs_r0, obs_r1, e_r0, e_r1);
            end
            checks++;
            if ({write_en, w_addr, w_data, last_grant} !== {m_we, m_addr, m_data, m_lg}) begin
                errors++;
                $display("FAIL random_out i=%0d got we=%0b a=%0d d=%0h lg=%0b want we=%0b a=%0d d=%0h lg=%0b",
                         i, write_en, w_addr, w_data, last_grant, m_we, m_addr, m_data, m_lg);
            end
            if (v0 && e_r0) v0 = 1'b0;
            if (v1 && e_r1) v1 = 1'b0;
        end
        idle();
        for (int r = 0; r < NR; r++) begin
            checks++;
            if (rf[r] !== mem[r]) begin errors++; $display("FAIL random_rf r=%0d got %0h want %0h", r, rf[r], mem[r]); end
        end
    endtask

    task automatic test_midreset();
        logic [DW-1:0] old5;
        old5 = mem[5];
        step(1'b0, 1'b1, AW'(5), 32'd99, 1'b0, '0, '0);
        checks++;
        if (obs_r0 !== 1'b1) begin errors++; $display("FAIL midreset_accept got %0b want 1", obs_r0); end
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        checks++;
        if (write_en !== 1'b0) begin errors++; $display("FAIL midreset_we got %0b want 0", write_en); end
`ifdef RF_CLEAR_EN
        run_clear();
        old5 = '0;
`endif
        step(1'b0, 1'b1, AW'(9), 32'd1, 1'b0, '0, '0);
        checks++;
        if (obs_r0 !== 1'b1) begin errors++; $display("FAIL midreset_resume got %0b want 1", obs_r0); end
        checks++;
        if (rf[5] !== old5) begin errors++; $display("FAIL midreset_rf5 got %0h want %0h", rf[5], old5); end
        idle();
    endtask

    initial begin
        for (int r = 0; r < NR; r++) begin rf[r] = '0; mem[r] = '0; end
        m_we = 1'b0; m_lg = 1'b1; m_addr = '0; m_data = '0;
        test_reset();
        test_single();
        test_contention();
        test_reg0();
        test_held();
        test_random();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
